len_sched: RTL and testbench
============================

# len_sched

Round-robin scheduler that shares one `analsy_len` length-analysis unit among `NUM_REQ` requesters in the Huffman encode path. It accepts one bus word at a time from the requesters and issues it to the analyzer with a single-cycle `we`. It waits for `result_ready`, then returns the result to the requester that issued it. A watchdog aborts a transaction that never completes and flags an error.

## Interface
- `BUS_WIDTH`, 64: width of the data word and of the analyzer result.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `TIMEOUT`, 128: maximum number of WAIT cycles before abort, at least 2.
- `IDW`, `$clog2(NUM_REQ)`: localparam, width of the requester ID.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_data`  in  NUM_REQ*BUS_WIDTH  requester i's word is in slice `[i*BUS_WIDTH +: BUS_WIDTH]`.
- `req_ready`  out  NUM_REQ  one-hot accept; combinational.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle response strobe.
- `rsp_id`  out  IDW  index of the responding requester.
- `rsp_result`  out  BUS_WIDTH  analyzer result; 0 on error.
- `rsp_err`  out  1  the transaction timed out.
- `ana_we`  out  1  write strobe to the analyzer.
- `ana_din`  out  BUS_WIDTH  data to the analyzer.
- `ana_busy`  in  1  analyzer busy.
- `ana_result_ready`  in  1  analyzer result strobe.
- `ana_result`  in  BUS_WIDTH  analyzer result.
- `sched_busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is set and `ana_busy`=0, pick the winner by round-robin, searching from `last_id+1` modulo `NUM_REQ`.
  - Assert `req_ready[winner]` in the same cycle.
  - On that edge, latch `req_data` slice and ID into `hold_data`/`hold_id`, then go to ISSUE.
  - If `ana_busy`=1, `req_ready` stays all zero.
- ISSUE:
  - `ana_we`=1 and `ana_din`=`hold_data` for exactly one cycle.
  - Clear the timer; go to WAIT.
- WAIT:
  - Timer increments every cycle.
  - If `ana_result_ready`=1, latch `ana_result`, set err=0, go to RESP.
  - Otherwise, when the timer reaches `TIMEOUT`-1, set the latched result to 0 and err=1, then go to RESP.
  - If `ana_result_ready` and timeout coincide, `ana_result_ready` wins.
- RESP:
  - Drive `rsp_valid[hold_id]`=1, `rsp_id`=`hold_id`, `rsp_result`, `rsp_err` for one cycle.
  - Set `last_id`<=`hold_id`; go to IDLE.
- `ana_din` holds `hold_data` in all states; it is only meaningful while `ana_we`=1.
- `ana_result_ready` outside WAIT (late or stale results) is ignored.
- No response backpressure: requesters must sample `rsp_*` in the strobe cycle.
- A requester must hold `req_valid` and its data stable until it sees `req_ready`. Dropping `req_valid` before the grant is legal and loses nothing.
- Only one transaction is in flight at a time.

## Timing
- Reset values:
  - State IDLE, `last_id`=`NUM_REQ`-1, so requester 0 wins first.
  - Timer 0, `hold_*` 0.
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_err`, `ana_we`, `ana_din`, `sched_busy`.
- Accept cycle is t0:
  - `ana_we` is high at t0+1.
  - WAIT starts at t0+2.
- Analyzer latency L is the number of cycles from the `ana_we` cycle to the `result_ready` cycle, with L≥1. `rsp_valid` is high at t0+L+2.
- Next accept is possible in the cycle after RESP. Throughput is one transaction per L+3 cycles.
- On timeout, `rsp_valid`/`rsp_err` are high at t0+TIMEOUT+2.
- Reset in any state returns to IDLE on the next edge. The in-flight transaction is discarded with no response; the analyzer shares `rst`.

## Test plan
- Single request:
  - Stimulus: requester 2 sends `{20'b0,6'b010010,36'h012345678,2'b00}`; the analyzer model has L=3 and returns 42.
  - Required: `ana_we` one cycle with matching `ana_din`; `rsp_valid`=4'b0100, `rsp_id`=2, `rsp_result`=42, `rsp_err`=0 at t0+5.
- Contention:
  - Stimulus: all four requesters valid continuously after reset.
  - Required: grants in order 0,1,2,3,0; each `rsp_id` matches its grant; no overlap of `ana_we` between transactions.
- Busy gating:
  - Stimulus: `ana_busy`=1 for 10 cycles with requester 1 valid.
  - Required: `req_ready`=0 throughout; grant in the first cycle `ana_busy`=0.
- Timeout:
  - Stimulus: analyzer never raises `result_ready`, `TIMEOUT`=8.
  - Required: `rsp_err`=1, `rsp_result`=0 at t0+10. A late `ana_result_ready` in IDLE produces no response.
- Reset mid-WAIT:
  - Stimulus: assert `rst` two cycles into WAIT.
  - Required: no `rsp_valid`; all outputs 0 next cycle; the next request goes to requester 0 first.
- Coincident result and timeout:
  - Stimulus: `result_ready` exactly at timer=`TIMEOUT`-1.
  - Required: `rsp_err`=0 and the real result is returned.

Source files
------------

// File: rtl/len_sched.sv
// Round-robin scheduler sharing one length-analysis unit among NUM_REQ requesters.
// One transaction in flight; a watchdog aborts analyzer calls that never complete.
module len_sched #(
    parameter int BUS_WIDTH = 64,
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 128
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic [BUS_WIDTH-1:0]           rsp_result,
    output logic                           rsp_err,
    output logic                           ana_we,
    output logic [BUS_WIDTH-1:0]           ana_din,
    input  logic                           ana_busy,
    input  logic                           ana_result_ready,
    input  logic [BUS_WIDTH-1:0]           ana_result,
    output logic                           sched_busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT);
    localparam logic [TW-1:0]      TLAST  = TW'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONEHOT = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IDW-1:0]       r_last_id;
    logic [IDW-1:0]       r_hold_id;
    logic [BUS_WIDTH-1:0] r_hold_data;
    logic [BUS_WIDTH-1:0] r_result;
    logic                 r_err;
    logic [TW-1:0]        r_timer;

    logic                 w_found;
    logic [IDW-1:0]       w_win_id;
    logic                 w_grant;
    logic [BUS_WIDTH-1:0] w_win_data;
    logic                 w_timeout;

    // Search starts just past the last served requester so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[IDW'((int'(r_last_id) + 1 + k) % NUM_REQ)]) begin
                w_found  = 1'b1;
                w_win_id = IDW'((int'(r_last_id) + 1 + k) % NUM_REQ);
            end
        end
    end

    assign w_grant    = (r_state == S_IDLE) && w_found && !ana_busy;
    assign w_win_data = req_data[w_win_id*BUS_WIDTH +: BUS_WIDTH];
    assign w_timeout  = (r_timer == TLAST);
    assign ana_din    = r_hold_data;
    assign sched_busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_id     = '0;
        rsp_result = '0;
        rsp_err    = 1'b0;
        ana_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    req_ready = ONEHOT << w_win_id;
                    w_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ana_we = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (ana_result_ready || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid  = ONEHOT << r_hold_id;
                rsp_id     = r_hold_id;
                rsp_result = r_result;
                rsp_err    = r_err;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A real result in the last watchdog cycle still counts as success.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_id   <= IDW'(NUM_REQ - 1);
            r_hold_id   <= '0;
            r_hold_data <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_timer     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_hold_data <= w_win_data;
                        r_hold_id   <= w_win_id;
                    end
                end
                S_ISSUE: r_timer <= '0;
                S_WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    if (ana_result_ready) begin
                        r_result <= ana_result;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end
                end
                S_RESP: r_last_id <= r_hold_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_len_sched.sv
// Directed bench for len_sched: single request, contention, busy gating,
// timeout, reset mid-WAIT and coincident result/timeout.
module tb_len_sched;

    localparam int BW = 64;
    localparam int NR = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*BW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [1:0]      rsp_id;
    logic [BW-1:0]   rsp_result;
    logic            rsp_err;
    logic            ana_we;
    logic [BW-1:0]   ana_din;
    logic            ana_busy;
    logic            ana_result_ready;
    logic [BW-1:0]   ana_result;
    logic            sched_busy;

    int checks = 0;
    int errors = 0;

    logic [63:0] d1;
    logic [3:0]  oh;

    always #5 clk = ~clk;

    len_sched #(.BUS_WIDTH(BW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_id           (rsp_id),
        .rsp_result       (rsp_result),
        .rsp_err          (rsp_err),
        .ana_we           (ana_we),
        .ana_din          (ana_din),
        .ana_busy         (ana_busy),
        .ana_result_ready (ana_result_ready),
        .ana_result       (ana_result),
        .sched_busy       (sched_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},  64'(req_ready),  64'h0);
        chk({tag, "_rspv"},   64'(rsp_valid),  64'h0);
        chk({tag, "_rspid"},  64'(rsp_id),     64'h0);
        chk({tag, "_result"}, rsp_result,      64'h0);
        chk({tag, "_err"},    64'(rsp_err),    64'h0);
        chk({tag, "_we"},     64'(ana_we),     64'h0);
        chk({tag, "_din"},    ana_din,         64'h0);
        chk({tag, "_busy"},   64'(sched_busy), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; ana_busy = 1'b0;
        ana_result_ready = 1'b0; ana_result = '0;
        d1 = {20'b0, 6'b010010, 36'h012345678, 2'b00};
        step(); step(); #1;
        chk_all_zero("reset");
        step(); rst = 1'b0;

        // Single request from requester 2, analyzer latency 3
        step();
        req_data[2*BW +: BW] = d1; req_valid = 4'b0100; #1;
        chk("t1_ready", 64'(req_ready), 64'h4);
        chk("t1_idle_busy", 64'(sched_busy), 64'h0);
        step(); req_valid = '0; #1;
        chk("t1_we", 64'(ana_we), 64'h1);
        chk("t1_din", ana_din, d1);
        chk("t1_busy", 64'(sched_busy), 64'h1);
        step(); #1;
        chk("t1_we_once", 64'(ana_we), 64'h0);
        step();
        step(); ana_result_ready = 1'b1; ana_result = 64'd42; #1;
        chk("t1_early_rsp", 64'(rsp_valid), 64'h0);
        step(); ana_result_ready = 1'b0; ana_result = '0; #1;
        chk("t1_rspv", 64'(rsp_valid), 64'h4);
        chk("t1_rspid", 64'(rsp_id), 64'h2);
        chk("t1_result", rsp_result, 64'd42);
        chk("t1_err", 64'(rsp_err), 64'h0);
        step(); #1;
        chk("t1_rsp_once", 64'(rsp_valid), 64'h0);
        chk("t1_back_idle", 64'(sched_busy), 64'h0);

        // Contention: all requesters valid after reset, latency 1
        rst = 1'b1;
        for (int i = 0; i < NR; i++) req_data[i*BW +: BW] = 64'h1000 + 64'(i);
        req_valid = 4'hF;
        step(); rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << (g % 4);
            #1;
            chk("c_ready", 64'(req_ready), 64'(oh));
            step(); #1;
            chk("c_we", 64'(ana_we), 64'h1);
            chk("c_din", ana_din, 64'h1000 + 64'(g % 4));
            chk("c_no_ready_issue", 64'(req_ready), 64'h0);
            step(); ana_result_ready = 1'b1; ana_result = 64'h500 + 64'(g); #1;
            chk("c_we_off", 64'(ana_we), 64'h0);
            step(); ana_result_ready = 1'b0; #1;
            chk("c_rspv", 64'(rsp_valid), 64'(oh));
            chk("c_rspid", 64'(rsp_id), 64'(g % 4));
            chk("c_result", rsp_result, 64'h500 + 64'(g));
            chk("c_no_ready_resp", 64'(req_ready), 64'h0);
            step();
        end
        req_valid = '0;

        // Busy gating with requester 1 waiting
        ana_busy = 1'b1; req_valid = 4'b0010; req_data[1*BW +: BW] = 64'hABCD_0001;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("b_ready_gated", 64'(req_ready), 64'h0);
            chk("b_idle", 64'(sched_busy), 64'h0);
            step();
        end
        ana_busy = 1'b0; #1;
        chk("b_grant", 64'(req_ready), 64'h2);
        step(); req_valid = '0; #1;
        chk("b_we", 64'(ana_we), 64'h1);
        chk("b_din", ana_din, 64'hABCD_0001);
        step(); ana_result_ready = 1'b1; ana_result = 64'd99;
        step(); ana_result_ready = 1'b0; #1;
        chk("b_rspv", 64'(rsp_valid), 64'h2);
        chk("b_result", rsp_result, 64'd99);
        step();

        // Timeout: analyzer never answers; requester 3
        req_valid = 4'b1000; req_data[3*BW +: BW] = 64'h3333; #1;
        chk("to_ready", 64'(req_ready), 64'h8);
        step(); req_valid = '0; ana_result = 64'hDEAD;
        repeat (8) step();
        #1;
        chk("to_no_early_rsp", 64'(rsp_valid), 64'h0);
        chk("to_still_busy", 64'(sched_busy), 64'h1);
        step(); #1;
        chk("to_rspv", 64'(rsp_valid), 64'h8);
        chk("to_err", 64'(rsp_err), 64'h1);
        chk("to_result", rsp_result, 64'h0);
        chk("to_rspid", 64'(rsp_id), 64'h3);
        step(); ana_result_ready = 1'b1; #1;
        chk("to_idle", 64'(sched_busy), 64'h0);
        step(); ana_result_ready = 1'b0; #1;
        chk("late_no_rsp", 64'(rsp_valid), 64'h0);
        chk("late_idle", 64'(sched_busy), 64'h0);

        // Reset two cycles into WAIT; requester 1
        req_valid = 4'b0010; req_data[1*BW +: BW] = 64'h5555; #1;
        chk("r_ready", 64'(req_ready), 64'h2);
        step(); req_valid = '0;
        step();
        step(); rst = 1'b1;
        step(); rst = 1'b0; #1;
        chk_all_zero("r_after");
        step(); #1;
        chk("r_no_rsp", 64'(rsp_valid), 64'h0);

        // After reset requester 0 wins; then result coincides with the last watchdog cycle
        req_data[0*BW +: BW] = 64'h7070; req_valid = 4'b0111; #1;
        chk("r_first", 64'(req_ready), 64'h1);
        step(); req_valid = '0; #1;
        chk("co_din", ana_din, 64'h7070);
        repeat (8) step();
        ana_result_ready = 1'b1; ana_result = 64'd77; #1;
        chk("co_no_early_rsp", 64'(rsp_valid), 64'h0);
        step(); ana_result_ready = 1'b0; #1;
        chk("co_rspv", 64'(rsp_valid), 64'h1);
        chk("co_err", 64'(rsp_err), 64'h0);
        chk("co_result", rsp_result, 64'd77);
        step(); #1;
        chk("co_idle", 64'(sched_busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
